pc_unit: RTL and testbench

PC_UNIT -- requirements
Module: pc_unit

---
 rtl/pc_pkg.sv | 16 +
 rtl/pc_ret_stack.sv | 49 ++++
 rtl/pc_unit.sv | 78 +++++++
 tb/tb_pc_unit.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/pc_pkg.sv
// Shared definitions for the program-counter unit: op encoding and op type.
// Used by the RTL decoder and by the testbench stimulus.
package pc_pkg;

    localparam int OP_W = 3;

    typedef enum logic [OP_W-1:0] {
        OP_INC    = 3'd0,
        OP_LOAD   = 3'd1,
        OP_BRANCH = 3'd2,
        OP_CALL   = 3'd3,
        OP_RET    = 3'd4,
        OP_HOLD   = 3'd5
    } op_t;

endpackage

// File: rtl/pc_ret_stack.sv
// LIFO return-address stack with depth counter and empty/full decode.
// A push while full and a pop while empty are silently ignored.
module pc_ret_stack #(
    parameter int PC_W        = 8,
    parameter int STACK_DEPTH = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            push,
    input  logic            pop,
    input  logic [PC_W-1:0] push_data,
    output logic [PC_W-1:0] top,
    output logic            empty,
    output logic            full
);

    localparam int DW = $clog2(STACK_DEPTH + 1);
    localparam int IW = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

    logic [DW-1:0]   depth;
    logic [PC_W-1:0] mem [STACK_DEPTH];
    logic [IW-1:0]   wr_idx;
    logic [IW-1:0]   rd_idx;

    assign wr_idx = IW'(depth);
    assign rd_idx = IW'(depth - DW'(1));

    assign empty = (depth == '0);
    assign full  = (depth == DW'(STACK_DEPTH));
    assign top   = mem[rd_idx];

    always_ff @(posedge clk) begin
        if (rst) begin
            depth <= '0;
        end else if (push && !full) begin
            depth <= depth + DW'(1);
        end else if (pop && !empty) begin
            depth <= depth - DW'(1);
        end
    end

    // NOTE: storage is deliberately not reset; entries above depth are never read.
    always_ff @(posedge clk) begin
        if (push && !full) begin
            mem[wr_idx] <= push_data;
        end
    end

endmodule

// File: rtl/pc_unit.sv
// Program counter with increment, load, relative branch and call/return,
// plus sticky overflow/underflow flags for the return stack.
module pc_unit
    import pc_pkg::*;
#(
    parameter int              PC_W        = 8,
    parameter int              STACK_DEPTH = 4,
    parameter logic [PC_W-1:0] RST_VEC     = '0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            en,
    input  logic [OP_W-1:0] op,
    input  logic [PC_W-1:0] data,
    output logic [PC_W-1:0] pc,
    output logic            stack_empty,
    output logic            stack_full,
    output logic            ovf_err,
    output logic            unf_err
);

    logic            push;
    logic            pop;
    logic [PC_W-1:0] pc_inc;
    logic [PC_W-1:0] stack_top;

    assign pc_inc = pc + PC_W'(1);
    assign push   = en && (op == OP_CALL) && !stack_full;
    assign pop    = en && (op == OP_RET) && !stack_empty;

    pc_ret_stack #(
        .PC_W        (PC_W),
        .STACK_DEPTH (STACK_DEPTH)
    ) u_stack (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .pop       (pop),
        .push_data (pc_inc),
        .top       (stack_top),
        .empty     (stack_empty),
        .full      (stack_full)
    );

    // NOTE: all state here uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc      <= RST_VEC;
            ovf_err <= 1'b0;
            unf_err <= 1'b0;
        end else if (en) begin
            case (op)
                OP_INC:    pc <= pc_inc;
                OP_LOAD:   pc <= data;
                // Unsigned modular add equals a two's-complement signed offset add.
                OP_BRANCH: pc <= pc + data;
                OP_CALL: begin
                    if (stack_full) begin
                        pc      <= pc_inc;
                        ovf_err <= 1'b1;
                    end else begin
                        pc <= data;
                    end
                end
                OP_RET: begin
                    if (stack_empty) begin
                        pc      <= pc_inc;
                        unf_err <= 1'b1;
                    end else begin
                        pc <= stack_top;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_pc_unit.sv
// Scoreboard bench for pc_unit: stimulus pushes model predictions into a queue,
// a monitor pops one per cycle and compares against the DUT outputs.
module tb_pc_unit;
    import pc_pkg::*;

    localparam int PC_W  = 8;
    localparam int DEPTH = 4;

    typedef struct {
        logic [PC_W-1:0] pc;
        bit              empty;
        bit              full;
        bit              ovf;
        bit              unf;
        int              id;
    } exp_t;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            en = 1'b0;
    logic [2:0]      op = 3'd0;
    logic [PC_W-1:0] data = '0;
    logic [PC_W-1:0] pc;
    logic            stack_empty;
    logic            stack_full;
    logic            ovf_err;
    logic            unf_err;

    exp_t            exp_q[$];
    int              n_cmp = 0;
    int              n_fail = 0;
    int              step_id = 0;

    // Reference model state
    int              m_pc = 0;
    int              m_stk[$];
    bit              m_ovf = 0;
    bit              m_unf = 0;

    pc_unit #(
        .PC_W        (PC_W),
        .STACK_DEPTH (DEPTH),
        .RST_VEC     (8'h00)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .op          (op),
        .data        (data),
        .pc          (pc),
        .stack_empty (stack_empty),
        .stack_full  (stack_full),
        .ovf_err     (ovf_err),
        .unf_err     (unf_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int id, input int got, input int want);
        n_cmp++;
        if (got != want) begin
            n_fail++;
            $display("FAIL step %0d %s: got 0x%0h expected 0x%0h", id, name, got, want);
        end
    endtask

    task automatic step(input bit r, input bit e, input logic [2:0] o, input logic [PC_W-1:0] d);
        exp_t x;
        @(negedge clk);
        rst  = r;
        en   = e;
        op   = o;
        data = d;
        if (r) begin
            m_pc = 0;
            m_stk.delete();
            m_ovf = 0;
            m_unf = 0;
        end else if (e) begin
            case (o)
                OP_INC:    m_pc = (m_pc + 1) % 256;
                OP_LOAD:   m_pc = int'(d);
                OP_BRANCH: m_pc = (m_pc + int'($signed(d))) & 255;
                OP_CALL: begin
                    if (m_stk.size() < DEPTH) begin
                        m_stk.push_back((m_pc + 1) % 256);
                        m_pc = int'(d);
                    end else begin
                        m_pc = (m_pc + 1) % 256;
                        m_ovf = 1;
                    end
                end
                OP_RET: begin
                    if (m_stk.size() > 0) begin
                        m_pc = m_stk.pop_back();
                    end else begin
                        m_pc = (m_pc + 1) % 256;
                        m_unf = 1;
                    end
                end
                default: ;
            endcase
        end
        x.pc    = PC_W'(m_pc);
        x.empty = (m_stk.size() == 0);
        x.full  = (m_stk.size() == DEPTH);
        x.ovf   = m_ovf;
        x.unf   = m_unf;
        x.id    = step_id;
        step_id++;
        exp_q.push_back(x);
    endtask

    // Monitor: every cycle the DUT presents a new pc, compare with the oldest prediction.
    initial begin
        exp_t x;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                x = exp_q.pop_front();
                check("pc", x.id, int'(pc), int'(x.pc));
                check("stack_empty", x.id, int'(stack_empty), int'(x.empty));
                check("stack_full", x.id, int'(stack_full), int'(x.full));
                check("ovf_err", x.id, int'(ovf_err), int'(x.ovf));
                check("unf_err", x.id, int'(unf_err), int'(x.unf));
            end
        end
    end

    initial begin
        // Reset, three increments, then two idle cycles holding pc
        step(1, 0, OP_INC, 8'h00);
        repeat (3) step(0, 1, OP_INC, 8'h00);
        step(0, 0, OP_LOAD, 8'hAA);
        step(0, 0, OP_CALL, 8'h55);

        // Load near the top and wrap
        step(0, 1, OP_LOAD, 8'hFE);
        repeat (2) step(0, 1, OP_INC, 8'h00);

        // Relative branches, backward then forward
        step(0, 1, OP_LOAD, 8'h10);
        step(0, 1, OP_BRANCH, 8'hFC);
        step(0, 1, OP_BRANCH, 8'h7F);

        // Nested call/return
        step(0, 1, OP_LOAD, 8'h20);
        step(0, 1, OP_CALL, 8'h40);
        step(0, 1, OP_CALL, 8'h60);
        step(0, 1, OP_RET, 8'h00);
        step(0, 1, OP_RET, 8'h00);

        // Overflow on the fifth call, then unwind four levels
        step(1, 1, OP_INC, 8'h00);
        for (int i = 1; i <= 5; i++) step(0, 1, OP_CALL, PC_W'(i * 16));
        step(0, 1, OP_HOLD, 8'h99);
        step(0, 1, 3'd7, 8'h99);
        repeat (4) step(0, 1, OP_RET, 8'h00);

        // Underflow, then reset with a partly full stack
        step(0, 1, OP_LOAD, 8'h05);
        step(0, 1, OP_RET, 8'h00);
        step(0, 1, OP_CALL, 8'h80);
        step(0, 1, OP_CALL, 8'h90);
        step(1, 1, OP_CALL, 8'hA0);
        step(0, 1, OP_RET, 8'h00);

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            step($urandom_range(0, 59) == 0, $urandom_range(0, 9) != 0,
                 3'($urandom_range(0, 7)), PC_W'($urandom_range(0, 255)));
        end

        @(negedge clk);
        en = 1'b0;
        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
        #2;
        if (exp_q.size() > 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL drain: got %0d pending predictions expected 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
